// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl
//
// Scan controller for a 4-digit, time-multiplexed seven-segment display.
// The display is scanned one digit at a time. Each digit slot has two parts:
//   BLANK - all digits are dark for BLANK_CYCLES cycles, which suppresses ghosting
//   SHOW  - digit idx is lit for SHOW_CYCLES cycles
// After the SHOW part, idx advances to the next digit. A frame is four slots.
//
// New display values pass through a one-entry pending buffer. The buffer is
// copied to the hex outputs only at the frame boundary (SHOW of digit 3 -> BLANK of
// digit 0). This means a digit never changes value while it is lit.
//
// Load handshake: a transfer happens in any cycle where load_valid & load_ready.
// load_ready is simply "pending buffer empty". The requester holds load_valid
// and load_data steady until the transfer happens.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   load_valid/ready    load handshake; load_data[4i+3:4i] is the nibble for digit i
//   digit_mask[3:0]     1 = digit i may light; sampled every cycle
//   hex0..hex3          committed nibbles for the segment decoder
//   an[3:0]             active-low digit enables (registered, at most one low)
//   frame_done          one-cycle pulse in the first BLANK cycle of each new frame
//
// The scan state (state_q, idx_q, cnt_q) is kept in plainly named flops so
// external checkers can observe it.
module ssd_scan_ctrl #(
  parameter int unsigned SHOW_CYCLES  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  input  logic [3:0]  digit_mask,
  output logic [3:0]  hex0,
  output logic [3:0]  hex1,
  output logic [3:0]  hex2,
  output logic [3:0]  hex3,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int unsigned MAX_CYCLES = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      an_q, an_d;
  logic            frame_done_q, frame_done_d;
  logic [15:0]     hex_q, hex_d;
  logic [15:0]     pend_q, pend_d;
  logic            pend_full_q, pend_full_d;
  logic            boundary;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q + CW'(1);
    hex_d        = hex_q;
    pend_d       = pend_q;
    pend_full_d  = pend_full_q;
    boundary     = 1'b0;

    case (state_q)
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
        end
      end
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d  = BLANK;
          cnt_d    = '0;
          idx_d    = idx_q + 2'd1;
          boundary = (idx_q == 2'd3);
        end
      end
      default: begin
        state_d = BLANK;
        cnt_d   = '0;
      end
    endcase

    frame_done_d = boundary;

    // Commit and accept are mutually exclusive: commit needs the buffer full,
    // and accept needs it empty. This also means a value accepted in the
    // boundary cycle waits for the following frame.
    if (boundary && pend_full_q) begin
      hex_d       = pend_q;
      pend_full_d = 1'b0;
    end
    if (load_valid && !pend_full_q) begin
      pend_d      = load_data;
      pend_full_d = 1'b1;
    end

    // an is registered. It is built from the next state, so it lines up with
    // state_q in the cycle where it is driven.
    an_d = 4'b1111;
    if (state_d == SHOW) begin
      an_d[idx_d] = ~digit_mask[idx_d];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= BLANK;
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      an_q         <= 4'b1111;
      frame_done_q <= 1'b0;
      hex_q        <= 16'h0000;
      pend_q       <= 16'h0000;
      pend_full_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
      hex_q        <= hex_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
    end
  end

  assign load_ready = ~pend_full_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;
  assign hex0       = hex_q[3:0];
  assign hex1       = hex_q[7:4];
  assign hex2       = hex_q[11:8];
  assign hex3       = hex_q[15:12];

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Testbench for ssd_scan_ctrl with BLANK_CYCLES=2 and SHOW_CYCLES=3, which
// gives a 20-cycle frame. Cycle k after reset release is sampled at its
// falling edge. The inputs for cycle k are driven at that same falling edge.
module tb_ssd_scan_ctrl;

  logic        clk;
  logic        reset;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic [3:0]  digit_mask;
  logic [3:0]  hex0, hex1, hex2, hex3;
  logic [3:0]  an;
  logic        frame_done;

  int n_vec;
  int n_err;

  ssd_scan_ctrl #(
    .SHOW_CYCLES (3),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .digit_mask(digit_mask),
    .hex0      (hex0),
    .hex1      (hex1),
    .hex2      (hex2),
    .hex3      (hex3),
    .an        (an),
    .frame_done(frame_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mask;
    logic        lv;
    logic [15:0] ld;
    int          n;
    logic [3:0]  exp_an;
    logic        exp_fd;
    logic        exp_rdy;
    logic [15:0] exp_hex;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [3:0] mask, input logic lv, input logic [15:0] ld,
                              input int n, input logic [3:0] exp_an, input logic exp_fd,
                              input logic exp_rdy, input logic [15:0] exp_hex);
    vec_t v;
    v.mask = mask; v.lv = lv; v.ld = ld; v.n = n;
    v.exp_an = exp_an; v.exp_fd = exp_fd; v.exp_rdy = exp_rdy; v.exp_hex = exp_hex;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_an, input logic e_fd,
                         input logic e_rdy, input logic [15:0] e_hex);
    chk({tag, " an"}, {12'h0, an}, {12'h0, e_an});
    chk({tag, " frame_done"}, {15'h0, frame_done}, {15'h0, e_fd});
    chk({tag, " load_ready"}, {15'h0, load_ready}, {15'h0, e_rdy});
    chk({tag, " hex"}, {hex3, hex2, hex1, hex0}, e_hex);
  endtask

  // Releases reset just after a rising edge. The next falling edge is then cycle 1.
  task automatic do_reset();
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = 16'h0;
    digit_mask = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    load_valid = 1'b0;
    load_data = 16'h0;
    digit_mask = 4'b1111;

    // Frame 1: mask 1111, nothing loaded, no frame_done yet.
    add(4'hF, 0, 16'h0, 2, 4'b1111, 0, 1, 16'h0000);
    add(4'hF, 0, 16'h0, 3, 4'b1110, 0, 1, 16'h0000);
    add(4'hF, 0, 16'h0, 2, 4'b1111, 0, 1, 16'h0000);
    add(4'hF, 0, 16'h0, 3, 4'b1101, 0, 1, 16'h0000);
    add(4'hF, 0, 16'h0, 2, 4'b1111, 0, 1, 16'h0000);
    add(4'hF, 0, 16'h0, 3, 4'b1011, 0, 1, 16'h0000);
    add(4'hF, 0, 16'h0, 2, 4'b1111, 0, 1, 16'h0000);
    add(4'hF, 0, 16'h0, 3, 4'b0111, 0, 1, 16'h0000);
    // Frame 2 (cycle 21): frame_done, then BEEF pulsed mid-frame (cycle 26).
    add(4'hF, 0, 16'h0,    1, 4'b1111, 1, 1, 16'h0000);
    add(4'hF, 0, 16'h0,    1, 4'b1111, 0, 1, 16'h0000);
    add(4'hF, 0, 16'h0,    3, 4'b1110, 0, 1, 16'h0000);
    add(4'hF, 1, 16'hBEEF, 1, 4'b1111, 0, 1, 16'h0000);
    add(4'hF, 0, 16'h0,    1, 4'b1111, 0, 0, 16'h0000);
    add(4'hF, 0, 16'h0,    3, 4'b1101, 0, 0, 16'h0000);
    add(4'hF, 0, 16'h0,    2, 4'b1111, 0, 0, 16'h0000);
    add(4'hF, 0, 16'h0,    3, 4'b1011, 0, 0, 16'h0000);
    add(4'hF, 0, 16'h0,    2, 4'b1111, 0, 0, 16'h0000);
    add(4'hF, 0, 16'h0,    3, 4'b0111, 0, 0, 16'h0000);
    // Frame 3: BEEF committed, mask 0101 -> digits 1 and 3 stay dark.
    add(4'h5, 0, 16'h0, 1, 4'b1111, 1, 1, 16'hBEEF);
    add(4'h5, 0, 16'h0, 1, 4'b1111, 0, 1, 16'hBEEF);
    add(4'h5, 0, 16'h0, 3, 4'b1110, 0, 1, 16'hBEEF);
    add(4'h5, 0, 16'h0, 2, 4'b1111, 0, 1, 16'hBEEF);
    add(4'h5, 0, 16'h0, 3, 4'b1111, 0, 1, 16'hBEEF);
    add(4'h5, 0, 16'h0, 2, 4'b1111, 0, 1, 16'hBEEF);
    add(4'h5, 0, 16'h0, 3, 4'b1011, 0, 1, 16'hBEEF);
    add(4'h5, 0, 16'h0, 2, 4'b1111, 0, 1, 16'hBEEF);
    add(4'h5, 0, 16'h0, 3, 4'b1111, 0, 1, 16'hBEEF);
    // Frame 4: 00A5 accepted in the frame_done cycle, held for a whole frame.
    add(4'hF, 1, 16'h00A5, 1, 4'b1111, 1, 1, 16'hBEEF);
    add(4'hF, 0, 16'h0,    1, 4'b1111, 0, 0, 16'hBEEF);
    add(4'hF, 0, 16'h0,    3, 4'b1110, 0, 0, 16'hBEEF);
    add(4'hF, 0, 16'h0,    2, 4'b1111, 0, 0, 16'hBEEF);
    add(4'hF, 0, 16'h0,    3, 4'b1101, 0, 0, 16'hBEEF);
    add(4'hF, 0, 16'h0,    2, 4'b1111, 0, 0, 16'hBEEF);
    add(4'hF, 0, 16'h0,    3, 4'b1011, 0, 0, 16'hBEEF);
    add(4'hF, 0, 16'h0,    2, 4'b1111, 0, 0, 16'hBEEF);
    add(4'hF, 0, 16'h0,    3, 4'b0111, 0, 0, 16'hBEEF);
    // Frame 5: 00A5 committed.
    add(4'hF, 0, 16'h0, 1, 4'b1111, 1, 1, 16'h00A5);
    add(4'hF, 0, 16'h0, 1, 4'b1111, 0, 1, 16'h00A5);

    // Reset state while reset is held.
    #2;
    chk_all("reset", 4'b1111, 0, 1, 16'h0000);

    do_reset();
    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        @(negedge clk);
        chk_all($sformatf("vec%0d.%0d", i, k), vecs[i].exp_an, vecs[i].exp_fd,
                vecs[i].exp_rdy, vecs[i].exp_hex);
        digit_mask = vecs[i].mask;
        load_valid = vecs[i].lv;
        load_data  = vecs[i].ld;
      end
    end
    load_valid = 1'b0;

    // Back-pressure: BEEF is taken in cycle 1. The bench then holds 1234,
    // which is only taken in the frame_done cycle (cycle 21) and is shown at
    // cycle 41. 5A5A is loaded at cycle 42 so the buffer is full for the
    // reset test that follows.
    do_reset();
    for (int c = 1; c <= 54; c++) begin
      logic        e_rdy;
      logic        e_fd;
      logic [15:0] e_hex;
      @(negedge clk);
      e_rdy = (c == 1) || (c == 21) || (c == 41) || (c == 42);
      e_fd  = (c == 21) || (c == 41);
      e_hex = (c < 21) ? 16'h0000 : (c < 41) ? 16'hBEEF : 16'h1234;
      chk($sformatf("bp%0d load_ready", c), {15'h0, load_ready}, {15'h0, e_rdy});
      chk($sformatf("bp%0d frame_done", c), {15'h0, frame_done}, {15'h0, e_fd});
      chk($sformatf("bp%0d hex", c), {hex3, hex2, hex1, hex0}, e_hex);
      if (c == 4)  chk("bp4 an",  {12'h0, an}, 16'h000E);
      if (c == 54) chk("bp54 an", {12'h0, an}, 16'h000B);
      if (c == 1) begin
        load_valid = 1'b1; load_data = 16'hBEEF;
      end else if (c <= 21) begin
        load_valid = 1'b1; load_data = 16'h1234;
      end else if (c == 42) begin
        load_valid = 1'b1; load_data = 16'h5A5A;
      end else begin
        load_valid = 1'b0; load_data = 16'h0;
      end
    end

    // Asynchronous reset during the SHOW part of digit 2, with the buffer full.
    // The outputs must clear with no clock edge.
    #1;
    reset = 1'b1;
    #1;
    chk_all("async_rst", 4'b1111, 0, 1, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk_all($sformatf("post_rst%0d", c), (c == 3) ? 4'b1110 : 4'b1111, 0, 1, 16'h0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
Time-multiplexing scan controller for the 4-digit seven-segment display. It cycles one active-low digit enable at a time, inserts a blanking gap between digits to suppress ghosting, and drives the four hex nibbles into the segment decoder. New display values arrive through a valid/ready load port. They are double-buffered and committed only at frame boundaries, so a digit never changes while it is lit.

Parameters:
SHOW_CYCLES, 100000, clock cycles a digit is lit per slot (>=1)
BLANK_CYCLES, 1000, clock cycles all digits are dark before each slot (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
load_valid  input  1  load request
load_data  input  16  new value; [3:0]=digit0 … [15:12]=digit3
load_ready  output  1  pending buffer empty; load accepted when load_valid & load_ready
digit_mask  input  4  per-digit enable, 1=digit may light (sampled live)
hex0  output  4  committed nibble, digit0 (to decoder hex)
hex1  output  4  committed nibble, digit1
hex2  output  4  committed nibble, digit2
hex3  output  4  committed nibble, digit3
an  output  4  active-low digit enables; an[i] drives enableD(i+1)
frame_done  output  1  one-cycle pulse at each frame boundary

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Asserting reset forces all state immediately, regardless of clk:
  - an=4'b1111
  - hex0..hex3=0
  - frame_done=0
  - pending buffer emptied, so load_ready=1
  - state=BLANK, digit index=0, slot counter=0
- Reset mid-operation: a pending value is discarded and the current slot is abandoned. The first cycle after release is cycle 0 of BLANK for digit 0.
- State machine, two states plus a 2-bit digit index idx and a slot counter of width $clog2(max(SHOW_CYCLES,BLANK_CYCLES)):
  - BLANK: an=1111 for exactly BLANK_CYCLES cycles, then go to SHOW with the counter cleared.
  - SHOW: for exactly SHOW_CYCLES cycles, an[idx]=~digit_mask[idx] and all other bits =1. Then go to BLANK with idx=idx+1 mod 4.
- Frame period is 4*(BLANK_CYCLES+SHOW_CYCLES) cycles. Scan timing is independent of digit_mask.
- Outputs: an and frame_done are registered, with no combinational path from inputs. At most one an bit is low in any cycle, which the decoder's priority chain requires.
- Frame boundary: the transition SHOW(idx=3) -> BLANK(idx=0). On that edge:
  - frame_done=1 for the first BLANK cycle of digit 0 only.
  - If the pending buffer is full, hex0..hex3 take the pending value and the buffer empties. Otherwise hex is unchanged.
  - hex outputs change only on this edge.
- Load handshake:
  - load_ready = ~pending_full.
  - On accept, load_data is captured into pending. load_ready goes 0 from the next cycle until the commit edge, and returns to 1 on that edge.
  - load_valid while load_ready=0 is ignored; the requester holds its data.
  - No bypass: a load accepted on the boundary cycle itself, with pending empty, is held and committed at the following boundary.
- Width/wrap: idx wraps 3->0 naturally. Counters compare against the parameter value minus 1 and clear on state change; no overflow is possible.

Test Plan:
1. BLANK=2, SHOW=3, mask=1111, release reset:
   - an sequence is 1111×2, 1110×3, 1111×2, 1101×3, 1111×2, 1011×3, 1111×2, 0111×3, then repeats.
   - frame_done pulses every 20 cycles, first at the 21st cycle after release.
   - hex0..3=0 throughout.
2. Mid-frame, pulse load_valid with 16'hBEEF (ready=1):
   - load_ready=0 from the next cycle.
   - hex unchanged until the frame_done cycle, when hex3..hex0 = B,E,E,F and load_ready=1.
3. Hold load_valid with 16'h1234 while pending holds 16'hBEEF:
   - 1234 is not accepted until the BEEF commit edge.
   - 1234 is accepted the cycle ready returns and displays one frame later.
4. mask=4'b0101:
   - digit1 and digit3 slots keep an=1111.
   - digit0/digit2 slots show 1110/1011.
   - slot timing and frame_done period are identical to scenario 1.
5. Assert reset during SHOW of digit 2 with pending full:
   - an=1111, hex=0, load_ready=1 immediately, without a clock edge.
   - After release, 2 BLANK cycles precede an=1110.
6. Accept load 16'h00A5 in the frame_done cycle with pending empty:
   - hex stays unchanged for that frame.
   - hex becomes 0,0,A,5 at the next frame_done, 20 cycles later.
